// File: rtl/tone_meas_pkg.sv
// Shared types and constants for the tone period meter.
package tone_meas_pkg;

    // Measurement FSM: IDLE waits for the first edge, MEASURE times the gaps between edges
    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meas_state_e;

    // Averaging mode: one result per AVG_SAMPLES good half-periods, divided by 2**AVG_SHIFT
    localparam int AVG_SAMPLES = 4;
    localparam int AVG_SHIFT   = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Input synchronizer and edge detector for the asynchronous tone input.
// The edge pulse is registered and fires for one clock on rising and falling transitions.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_edge;

    // Shift the raw input through the synchronizer and flag any change of the synced level
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_edge <= r_sync[SYNC_STAGES-1] ^ r_prev;
        end
    end

    assign o_edge = r_edge;

endmodule

// File: rtl/tone_period_meter.sv
// Tone period meter: measures clk cycles between consecutive edges of a 1-bit tone input
// and delivers each half-period through a valid/ready result register.
// Optional feature macro TONE_PERIOD_AVG_EN: report the mean of 4 good half-periods
// instead of every raw half-period.
module tone_period_meter
    import tone_meas_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_HALF    = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_sig_in,
    output logic             o_meas_valid,
    input  logic             i_meas_ready,
    output logic [CNT_W-1:0] o_half_period,
    output logic             o_overflow,
    output logic             o_locked,
    output logic             o_overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_HALF);

    logic             w_edge;
    meas_state_e      r_state;
    meas_state_e      w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_locked;
    logic             w_locked_next;
    logic             w_good_edge;
    logic             w_timeout;
    logic             w_new_result;
    logic [CNT_W-1:0] w_new_hp;
    logic             w_new_ovf;
    logic             r_valid;
    logic [CNT_W-1:0] r_half_period;
    logic             r_overflow;
    logic             r_overrun;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_sig_in),
        .o_edge  (w_edge)
    );

    // State, counter and lock flag registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_locked <= w_locked_next;
        end
    end

    // Next-state logic: edges that arrive too soon are glitches and the saturation test runs before the increment
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_locked_next = r_locked;
        w_good_edge   = 1'b0;
        w_timeout     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_edge) begin
                    w_state_next = MEASURE;
                    w_cnt_next   = CNT_W'(1);
                end
            end
            MEASURE: begin
                if (w_edge && (r_cnt >= MIN_CNT)) begin
                    w_good_edge   = 1'b1;
                    w_cnt_next    = CNT_W'(1);
                    w_locked_next = 1'b1;
                end else if (r_cnt == CNT_MAX) begin
                    w_timeout     = 1'b1;
                    w_cnt_next    = '0;
                    w_locked_next = 1'b0;
                    w_state_next  = IDLE;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

`ifdef TONE_PERIOD_AVG_EN
    localparam int                 N_W         = $clog2(AVG_SAMPLES);
    localparam logic [N_W-1:0]     LAST_SAMPLE = N_W'(AVG_SAMPLES - 1);

    logic [CNT_W+1:0] r_acc;
    logic [N_W-1:0]   r_acc_n;
    logic [CNT_W+1:0] w_sum;

    // Running sum including the current half-period, so the fourth sample completes in the same cycle
    always_comb begin
        w_sum        = r_acc + {2'b00, r_cnt};
        w_new_result = w_timeout | (w_good_edge && (r_acc_n == LAST_SAMPLE));
        w_new_ovf    = w_timeout;
        w_new_hp     = w_timeout ? CNT_MAX : CNT_W'(w_sum >> AVG_SHIFT);
    end

    // Accumulate good half-periods; a timeout throws away a partial group
    always_ff @(posedge i_clk) begin
        if (i_reset || w_timeout) begin
            r_acc   <= '0;
            r_acc_n <= '0;
        end else if (w_good_edge) begin
            if (r_acc_n == LAST_SAMPLE) begin
                r_acc   <= '0;
                r_acc_n <= '0;
            end else begin
                r_acc   <= w_sum;
                r_acc_n <= r_acc_n + N_W'(1);
            end
        end
    end
`else
    // Every good edge and every timeout produces a raw result
    always_comb begin
        w_new_result = w_good_edge | w_timeout;
        w_new_ovf    = w_timeout;
        w_new_hp     = w_timeout ? CNT_MAX : r_cnt;
    end
`endif

    // Result register: a new result is dropped while an unaccepted one is held, which sets the sticky overrun flag
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid       <= 1'b0;
            r_half_period <= '0;
            r_overflow    <= 1'b0;
            r_overrun     <= 1'b0;
        end else if (w_new_result && (!r_valid || i_meas_ready)) begin
            r_valid       <= 1'b1;
            r_half_period <= w_new_hp;
            r_overflow    <= w_new_ovf;
        end else if (w_new_result) begin
            r_overrun <= 1'b1;
        end else if (r_valid && i_meas_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_meas_valid  = r_valid;
    assign o_half_period = r_half_period;
    assign o_overflow    = r_overflow;
    assign o_locked      = r_locked;
    assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_tone_period_meter.sv
// Self-checking bench for tone_period_meter: a 32-bit and an 8-bit instance share the stimulus;
// results accepted on the handshake are compared against an edge-list reference model.
`timescale 1ns/1ps
module tb_tone_period_meter;

    localparam int     SYNC  = 2;
    localparam int     MINH  = 2;
    localparam longint MAX32 = 64'h0000_0000_FFFF_FFFF;
    localparam longint MAX8  = 64'd255;

    typedef struct packed {
        logic        ovf;
        logic [31:0] hp;
    } result_t;

    typedef struct {
        int          gap;
        int          expCount;
        logic [31:0] expHp32;
        logic        expLocked32;
        logic [7:0]  expHp8;
        logic        expOvf8;
        logic        expLocked8;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sigIn = 1'b0;
    logic        measReady = 1'b1;
    logic        valid32, ovf32, locked32, overrun32;
    logic [31:0] hp32;
    logic        valid8, ovf8, locked8, overrun8;
    logic [7:0]  hp8;

    int      errorCount = 0;
    int      checkCount = 0;
    longint  cycleNum = 0;
    longint  edgeTimes[$];
    result_t got32[$];
    result_t got8[$];
    result_t expQ[$];
    vec_t    vecs[7];

    always #5 clock = ~clock;

    tone_period_meter #(.CNT_W(32), .SYNC_STAGES(SYNC), .MIN_HALF(MINH)) dut32 (
        .i_clk(clock), .i_reset(reset), .i_sig_in(sigIn), .o_meas_valid(valid32),
        .i_meas_ready(measReady), .o_half_period(hp32), .o_overflow(ovf32),
        .o_locked(locked32), .o_overrun(overrun32)
    );

    tone_period_meter #(.CNT_W(8), .SYNC_STAGES(SYNC), .MIN_HALF(MINH)) dut8 (
        .i_clk(clock), .i_reset(reset), .i_sig_in(sigIn), .o_meas_valid(valid8),
        .i_meas_ready(measReady), .o_half_period(hp8), .o_overflow(ovf8),
        .o_locked(locked8), .o_overrun(overrun8)
    );

    // Cycle counter used as the time base for edge timestamps
    always @(posedge clock) cycleNum <= cycleNum + 1;

    // Record every result that is transferred at the coming clock edge
    always @(negedge clock) begin
        if (!reset && valid32 && measReady) got32.push_back({ovf32, hp32});
        if (!reset && valid8 && measReady) got8.push_back({ovf8, 24'd0, hp8});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Wait gapCycles clocks, then toggle the tone input and log the edge time
    task automatic applyStimulus(input int gapCycles);
        tick(gapCycles);
        sigIn = ~sigIn;
        edgeTimes.push_back(cycleNum);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        sigIn = 1'b0;
        tick(3);
        got32.delete();
        got8.delete();
        edgeTimes.delete();
        reset = 1'b0;
    endtask

    task automatic pushExp(input longint value, input logic ovf);
        expQ.push_back({ovf, value[31:0]});
    endtask

    // Reference model: walk the edge timestamps, applying the glitch, timeout and (optional) averaging rules
    task automatic runModel(input longint maxCnt, input longint endTime);
        longint refT;
        longint d;
        longint accSum;
        int     accN;
        bit     measuring;
        expQ.delete();
        measuring = 0;
        refT = 0;
        accSum = 0;
        accN = 0;
        foreach (edgeTimes[i]) begin
            if (measuring && (edgeTimes[i] - refT) > maxCnt) begin
                pushExp(maxCnt, 1'b1);
                measuring = 0;
                accSum = 0;
                accN = 0;
            end
            if (!measuring) begin
                measuring = 1;
                refT = edgeTimes[i];
            end else begin
                d = edgeTimes[i] - refT;
                if (d >= MINH) begin
                    refT = edgeTimes[i];
`ifdef TONE_PERIOD_AVG_EN
                    accSum += d;
                    accN++;
                    if (accN == 4) begin
                        pushExp(accSum / 4, 1'b0);
                        accSum = 0;
                        accN = 0;
                    end
`else
                    pushExp(d, 1'b0);
`endif
                end
            end
        end
        if (measuring && (endTime - refT) > maxCnt) pushExp(maxCnt, 1'b1);
    endtask

    task automatic compareResults(input string tag, input bit use8);
        int      n;
        result_t g;
        n = use8 ? got8.size() : got32.size();
        checkOutput({tag, "Count"}, 64'(n), 64'(expQ.size()));
        for (int i = 0; i < n && i < expQ.size(); i++) begin
            g = use8 ? got8[i] : got32[i];
            checkOutput($sformatf("%sItem%0d", tag, i), 64'(g), 64'(expQ[i]));
        end
    endtask

    initial begin
        int sawValid;
        int gap;
        int r;

        vecs[0] = '{1,    0, 32'd0,    1'b0, 8'd0,   1'b0, 1'b0};
        vecs[1] = '{2,    1, 32'd2,    1'b1, 8'd2,   1'b0, 1'b1};
        vecs[2] = '{3,    1, 32'd3,    1'b1, 8'd3,   1'b0, 1'b1};
        vecs[3] = '{17,   1, 32'd17,   1'b1, 8'd17,  1'b0, 1'b1};
        vecs[4] = '{255,  1, 32'd255,  1'b1, 8'd255, 1'b0, 1'b1};
        vecs[5] = '{256,  1, 32'd256,  1'b1, 8'd255, 1'b1, 1'b0};
        vecs[6] = '{1000, 1, 32'd1000, 1'b1, 8'd255, 1'b1, 1'b0};

        $display("[TB] reset with toggling input");
        tick(1);
        for (int i = 0; i < 3; i++) begin
            sigIn = ~sigIn;
            tick(1);
        end
        checkOutput("rstValid", 64'(valid32), 64'd0);
        checkOutput("rstHp", 64'(hp32), 64'd0);
        checkOutput("rstOvf", 64'(ovf32), 64'd0);
        checkOutput("rstLocked", 64'(locked32), 64'd0);
        checkOutput("rstOverrun", 64'(overrun32), 64'd0);
        checkOutput("rstValid8", 64'(valid8), 64'd0);
        reset = 1'b0;
        sawValid = 0;
        for (int i = 0; i < SYNC + 6; i++) begin
            tick(1);
            if (valid32 || valid8) sawValid++;
        end
        checkOutput("rstNoValid", 64'(sawValid), 64'd0);
        checkOutput("rstLockedAfter", 64'(locked32), 64'd0);

`ifndef TONE_PERIOD_AVG_EN
        $display("[TB] tone 4000 and latency");
        doReset();
        measReady = 1'b1;
        applyStimulus(5);
        applyStimulus(4000);
        checkOutput("toneLockedEarly", 64'(locked32), 64'd0);
        tick(SYNC + 1);
        checkOutput("latencyEarly", 64'(valid32), 64'd0);
        tick(1);
        checkOutput("latencyValid", 64'(valid32), 64'd1);
        checkOutput("toneHp", 64'(hp32), 64'd4000);
        checkOutput("toneLocked", 64'(locked32), 64'd1);
        applyStimulus(4000 - (SYNC + 2));
        tick(10);
        checkOutput("toneCount", 64'(got32.size()), 64'd2);
        if (got32.size() == 2) checkOutput("toneSecond", 64'(got32[1]), {31'd0, 1'b0, 32'd4000});

        $display("[TB] table vectors");
        foreach (vecs[k]) begin
            doReset();
            applyStimulus(3);
            applyStimulus(vecs[k].gap);
            tick(SYNC + 6);
            checkOutput($sformatf("vec%0dCount32", k), 64'(got32.size()), 64'(vecs[k].expCount));
            checkOutput($sformatf("vec%0dHp32", k), 64'(got32.size() > 0 ? got32[0] : result_t'(0)), {31'd0, 1'b0, vecs[k].expHp32});
            checkOutput($sformatf("vec%0dLocked32", k), 64'(locked32), 64'(vecs[k].expLocked32));
            checkOutput($sformatf("vec%0dCount8", k), 64'(got8.size()), 64'(vecs[k].expCount));
            checkOutput($sformatf("vec%0dRes8", k), 64'(got8.size() > 0 ? got8[0] : result_t'(0)), {31'd0, vecs[k].expOvf8, 24'd0, vecs[k].expHp8});
            checkOutput($sformatf("vec%0dLocked8", k), 64'(locked8), 64'(vecs[k].expLocked8));
        end

        $display("[TB] backpressure");
        doReset();
        measReady = 1'b0;
        applyStimulus(3);
        applyStimulus(100);
        applyStimulus(120);
        applyStimulus(140);
        tick(SYNC + 4);
        checkOutput("bpValid", 64'(valid32), 64'd1);
        checkOutput("bpHeldHp", 64'(hp32), 64'd100);
        checkOutput("bpOverrun", 64'(overrun32), 64'd1);
        measReady = 1'b1;
        tick(1);
        checkOutput("bpDrained", 64'(valid32), 64'd0);
        checkOutput("bpAccepted", 64'(got32.size() > 0 ? got32[0] : result_t'(0)), {31'd0, 1'b0, 32'd100});
        checkOutput("bpOverrunSticky", 64'(overrun32), 64'd1);

        $display("[TB] accept and new result in the same cycle");
        doReset();
        measReady = 1'b0;
        applyStimulus(3);
        applyStimulus(100);
        tick(SYNC + 2);
        checkOutput("sameHeld", 64'(hp32), 64'd100);
        applyStimulus(130 - (SYNC + 2));
        tick(SYNC + 1);
        measReady = 1'b1;
        tick(1);
        checkOutput("sameValid", 64'(valid32), 64'd1);
        checkOutput("sameHp", 64'(hp32), 64'd130);
        checkOutput("sameNoOverrun", 64'(overrun32), 64'd0);
        tick(1);
        checkOutput("sameCount", 64'(got32.size()), 64'd2);

        $display("[TB] overflow on 8-bit counter");
        doReset();
        measReady = 1'b1;
        applyStimulus(3);
        applyStimulus(300);
        checkOutput("ovfResult8", 64'(got8.size() > 0 ? got8[0] : result_t'(0)), {31'd0, 1'b1, 24'd0, 8'd255});
        checkOutput("ovfFlag8", 64'(ovf8), 64'd1);
        checkOutput("ovfUnlocked8", 64'(locked8), 64'd0);
        applyStimulus(50);
        tick(SYNC + 3);
        checkOutput("ovfCount8", 64'(got8.size()), 64'd2);
        if (got8.size() == 2) checkOutput("ovfNext8", 64'(got8[1]), {31'd0, 1'b0, 24'd0, 8'd50});
        checkOutput("ovfRelocked8", 64'(locked8), 64'd1);
`else
        $display("[TB] averaging");
        doReset();
        measReady = 1'b1;
        applyStimulus(3);
        applyStimulus(100);
        applyStimulus(102);
        applyStimulus(98);
        applyStimulus(100);
        tick(SYNC + 6);
        checkOutput("avgCount", 64'(got32.size()), 64'd1);
        checkOutput("avgHp", 64'(got32.size() > 0 ? got32[0] : result_t'(0)), {31'd0, 1'b0, 32'd100});
        applyStimulus(50);
        applyStimulus(60);
        doReset();
        applyStimulus(3);
        applyStimulus(70);
        applyStimulus(70);
        tick(SYNC + 6);
        checkOutput("avgResetClears", 64'(got32.size()), 64'd0);
`endif

        $display("[TB] glitch inside a 200-cycle half-period");
        doReset();
        measReady = 1'b1;
        applyStimulus(3);
        applyStimulus(100);
        applyStimulus(1);
        applyStimulus(99);
        tick(300);
        runModel(MAX32, cycleNum);
        compareResults("glitch32", 1'b0);
        runModel(MAX8, cycleNum);
        compareResults("glitch8", 1'b1);

        $display("[TB] randomized edges");
        doReset();
        measReady = 1'b1;
        for (int i = 0; i < 80; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) gap = 1;
            else if (r <= 5) gap = int'($urandom_range(2, 40));
            else if (r <= 8) gap = int'($urandom_range(41, 250));
            else gap = int'($urandom_range(250, 400));
            applyStimulus(gap);
        end
        tick(400);
        runModel(MAX32, cycleNum);
        compareResults("rand32", 1'b0);
        runModel(MAX8, cycleNum);
        compareResults("rand8", 1'b1);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
